// File: rtl/sargantana_hpdc_pkg.sv
// Shared port map, port id type and arbiter state encoding for the L1.5 request path.
// Holds declarations only; it adds no logic and no latency.
package sargantana_hpdc_pkg;

  localparam int unsigned HPDC_NUM_PORTS = 6;

  localparam int unsigned ICACHE   = 0;
  localparam int unsigned DCACHE   = 1;
  localparam int unsigned WBUF     = 2;
  localparam int unsigned UC_READ  = 3;
  localparam int unsigned UC_WRITE = 4;
  localparam int unsigned AMO      = 5;

  typedef logic [$clog2(HPDC_NUM_PORTS)-1:0] portid_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sargantana_sat_counter.sv
// Saturating up/down counter that tracks one port's in-flight requests; the count updates one cycle after inc/dec.
// No backpressure: a simultaneous inc and dec cancel, and the count never wraps past 0 or Max.
module sargantana_sat_counter #(
  parameter int unsigned Width = 3,
  parameter int unsigned Max   = 4
) (
  input  logic             clk_i,
  input  logic             reset_l,
  input  logic             inc,
  input  logic             dec,
  output logic [Width-1:0] count,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [Width-1:0] MaxVal = Width'(Max);

  assign at_max  = (count == MaxVal);
  assign at_zero = (count == '0);

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      count <= '0;
    end else if (inc && !dec && !at_max) begin
      count <= count + Width'(1);
    end else if (dec && !inc && !at_zero) begin
      count <= count - Width'(1);
    end
  end

endmodule

// File: rtl/sargantana_l15_req_arbiter.sv
// Fixed-priority arbiter from NumPorts requesters to the L1.5: the grant is combinational, and the registered request appears on the next cycle.
// l15_val_o holds until header ack, which is followed by an IDLE bubble; a port whose outstanding count is at MaxOutstanding is not granted.
module sargantana_l15_req_arbiter
  import sargantana_hpdc_pkg::*;
#(
  parameter int unsigned NumPorts       = HPDC_NUM_PORTS,
  parameter int unsigned ReqWidth       = 128,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned PortIdW       = (NumPorts > 1) ? $clog2(NumPorts) : 1,
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_l,
  input  logic [NumPorts-1:0]          req_valid_i,
  output logic [NumPorts-1:0]          req_ready_o,
  input  logic [NumPorts*ReqWidth-1:0] req_data_i,
  output logic                         l15_val_o,
  output logic [ReqWidth-1:0]          l15_data_o,
  output logic [PortIdW-1:0]           l15_portid_o,
  input  logic                         l15_header_ack_i,
  input  logic                         rtrn_valid_i,
  input  logic [PortIdW-1:0]           rtrn_portid_i,
  output logic [NumPorts*CntW-1:0]     outstanding_o,
  output logic                         err_o
);

  arb_state_e          state;
  logic [NumPorts-1:0] at_max;
  logic [NumPorts-1:0] at_zero;
  logic [NumPorts-1:0] eligible;
  logic [NumPorts-1:0] grant;
  logic [NumPorts-1:0] inc;
  logic [NumPorts-1:0] dec;
  logic [CntW-1:0]     count [NumPorts];
  logic [PortIdW-1:0]  grant_idx;
  logic                any_eligible;
  logic                rtrn_err;
  logic                ack_err;

  // Eligibility uses the registered counts, so a return this cycle unblocks only on the next cycle.
  assign eligible = req_valid_i & ~at_max;

  always_comb begin
    grant        = '0;
    grant_idx    = '0;
    any_eligible = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      if (eligible[p] && !any_eligible) begin
        grant[p]     = 1'b1;
        grant_idx    = PortIdW'(p);
        any_eligible = 1'b1;
      end
    end
  end

  assign req_ready_o = (reset_l && state == IDLE) ? grant : '0;
  assign l15_val_o   = (state == REQ);

  always_comb begin
    inc = '0;
    dec = '0;
    for (int p = 0; p < NumPorts; p++) begin
      inc[p] = (state == REQ) && l15_header_ack_i && (l15_portid_o == PortIdW'(p));
      dec[p] = rtrn_valid_i && (rtrn_portid_i == PortIdW'(p)) && !at_zero[p];
    end
  end

  // A return that matches no port with a nonzero count is out of range or an underflow.
  assign rtrn_err = rtrn_valid_i && (dec == '0);
  assign ack_err  = l15_header_ack_i && (state != REQ);

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      state        <= IDLE;
      l15_data_o   <= '0;
      l15_portid_o <= '0;
      err_o        <= 1'b0;
    end else begin
      if (rtrn_err || ack_err) begin
        err_o <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (any_eligible) begin
            l15_data_o   <= req_data_i[32'(grant_idx)*ReqWidth +: ReqWidth];
            l15_portid_o <= grant_idx;
            state        <= REQ;
          end
        end
        REQ: begin
          if (l15_header_ack_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < NumPorts; p++) begin : g_cnt
    sargantana_sat_counter #(
      .Width (CntW),
      .Max   (MaxOutstanding)
    ) u_cnt (
      .clk_i   (clk_i),
      .reset_l (reset_l),
      .inc     (inc[p]),
      .dec     (dec[p]),
      .count   (count[p]),
      .at_max  (at_max[p]),
      .at_zero (at_zero[p])
    );
    assign outstanding_o[p*CntW +: CntW] = count[p];
  end

endmodule
